// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: access-size codes, FSM states, EX/MEM register layout.
// Also holds the alignment rule that both the RTL and the lane steering rely on.
package mem_stage_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [2:0] ST_B  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_W  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] store_data;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
  } ex_mem_t;

  // Low two funct3 bits encode the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for stores and lane select / extension for loads, plus access error flag.
// Zero latency; no flow control of its own.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic             is_load,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] store_data,
  input  logic [WIDTH-1:0] rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic             err
);

  logic [WIDTH-1:0] shifted;
  logic             illegal;

  always_comb begin
    be        = 4'b0000;
    wdata     = '0;
    illegal   = 1'b0;
    shifted   = rdata >> {addr_lo, 3'b000};
    load_data = rdata;

    if (is_load) begin
      case (funct3)
        LD_B:    load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
        LD_H:    load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
        LD_W:    load_data = rdata;
        LD_BU:   load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
        LD_HU:   load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
        default: illegal   = 1'b1;
      endcase
    end else begin
      // Data is replicated across every lane so the memory can pick it up with be alone.
      case (funct3)
        ST_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        ST_H: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        ST_W: begin
          be    = 4'b1111;
          wdata = store_data;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign err = illegal | is_misaligned(funct3, addr_lo);

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, req/gnt/rvalid data-memory port, MEM/WB register; 1 cycle EX->WB.
// Stalls upstream while waiting for gnt (stores) or gnt+rvalid (loads); bad accesses retire at once.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_alu_result,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [4:0]       ex_rd,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_reg_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             mem_stall,
  output logic [WIDTH-1:0] fwd_from_mem,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_mem_err
);

  ex_mem_t          ex_in;
  ex_mem_t          m;
  logic             m_valid;
  mem_state_t       state;
  mem_state_t       state_nxt;
  logic             access;
  logic             err;
  logic             good;
  logic             fsm_done;
  logic             retire;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] load_data;

  assign ex_in = '{alu_result: ex_alu_result,
                   store_data: ex_store_data,
                   rd:         ex_rd,
                   funct3:     ex_funct3,
                   mem_read:   ex_mem_read,
                   mem_write:  ex_mem_write,
                   reg_write:  ex_reg_write};

  mem_align u_align (
    .funct3     (m.funct3),
    .is_load    (m.mem_read),
    .addr_lo    (m.alu_result[1:0]),
    .store_data (m.store_data),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data),
    .err        (err)
  );

  assign access = m_valid & (m.mem_read | m.mem_write);
  assign good   = access & ~err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    fsm_done  = 1'b0;
    case (state)
      IDLE, REQ: begin
        if (good) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            state_nxt = m.mem_read ? WAIT : IDLE;
            fsm_done  = ~m.mem_read;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      // Responses are only honoured here; an rvalid seen in IDLE or REQ is dropped.
      WAIT: begin
        if (dmem_rvalid) begin
          fsm_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_stall    = good & ~fsm_done;
  assign retire       = m_valid & ~mem_stall;
  assign fwd_from_mem = m.alu_result;

  // Port fields are driven only alongside req, so they read zero between accesses.
  assign dmem_we    = dmem_req & ~m.mem_read;
  assign dmem_addr  = dmem_req ? {m.alu_result[WIDTH-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? be : 4'b0000;
  assign dmem_wdata = dmem_req ? wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m       <= '0;
      m_valid <= 1'b0;
    end else if (!mem_stall) begin
      m       <= ex_in;
      m_valid <= ex_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      wb_mem_err   <= 1'b0;
    end else begin
      wb_valid     <= retire;
      wb_reg_write <= retire & m.reg_write & ~(access & err);
      wb_mem_err   <= access & err;
      if (retire) begin
        wb_rd   <= m.rd;
        wb_data <= (good & m.mem_read) ? load_data : m.alu_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage with a behavioural memory-access reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_stall;
  logic [31:0] fwd_from_mem;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        wb_mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .fwd_from_mem(fwd_from_mem),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .wb_mem_err(wb_mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model. kind: 0 = ALU op, 1 = load, 2 = store.
  function automatic bit ref_err(input int kind, input int f3, input int a);
    bit ill;
    bit mis;
    int sz = f3 % 4;
    if (kind == 0) return 1'b0;
    ill = (kind == 1) ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
    mis = (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    return ill || mis;
  endfunction

  function automatic logic [31:0] ref_be(input int f3, input int a);
    if (f3 == 0) return 32'd1 << a;
    if (f3 == 1) return 32'd3 << ((a / 2) * 2);
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
    if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] rdata);
    logic [31:0] lane = rdata >> (8 * a);
    logic [31:0] v;
    case (f3)
      0: begin v = lane & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      1: begin v = lane & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      4: v = lane & 32'hFF;
      5: v = lane & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, ":req"}, dmem_req, 0);
    chk({tag, ":we"}, dmem_we, 0);
    chk({tag, ":addr"}, dmem_addr, 0);
    chk({tag, ":be"}, dmem_be, 0);
    chk({tag, ":wdata"}, dmem_wdata, 0);
    chk({tag, ":stall"}, mem_stall, 0);
    chk({tag, ":fwd"}, fwd_from_mem, 0);
    chk({tag, ":wb_valid"}, wb_valid, 0);
    chk({tag, ":wb_rd"}, wb_rd, 0);
    chk({tag, ":wb_reg_write"}, wb_reg_write, 0);
    chk({tag, ":wb_data"}, wb_data, 0);
    chk({tag, ":wb_mem_err"}, wb_mem_err, 0);
  endtask

  // Issue one instruction, play memory with gd cycles of gnt delay and rvalid rl cycles after gnt.
  task automatic run_instr(input string tag, input int kind, input int f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input int gd, input int rl, input logic [31:0] rdata);
    bit e       = ref_err(kind, f3, int'(addr % 4));
    bit mem     = (kind != 0) && !e;
    int done_at = !mem ? 0 : ((kind == 2) ? gd : gd + rl);
    @(posedge clk); #1;
    chk({tag, ":wb_valid_gap"}, wb_valid, 0);
    chk({tag, ":wb_err_gap"}, wb_mem_err, 0);
    ex_valid      = 1'b1;
    ex_alu_result = addr;
    ex_store_data = sdata;
    ex_rd         = rd;
    ex_funct3     = 3'(f3);
    ex_mem_read   = (kind == 1);
    ex_mem_write  = (kind == 2);
    ex_reg_write  = (kind != 2);
    @(posedge clk); #1;
    ex_valid      = 1'b0;
    ex_alu_result = $urandom;
    ex_store_data = $urandom;
    ex_rd         = 5'($urandom);
    for (int i = 0; i <= done_at; i++) begin
      dmem_gnt    = mem && (i == gd);
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (mem && kind == 1 && i == gd + rl) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end else if (mem && i >= 1 && i <= gd && $urandom_range(1) == 1) begin
        dmem_rvalid = 1'b1;
      end
      #3;
      chk({tag, ":stall"}, mem_stall, (mem && i < done_at));
      chk({tag, ":req"}, dmem_req, (mem && i <= gd));
      chk({tag, ":fwd"}, fwd_from_mem, addr);
      if (mem && i <= gd) begin
        chk({tag, ":addr"}, dmem_addr, addr & ~32'd3);
        chk({tag, ":we"}, dmem_we, (kind == 2));
        if (kind == 2) begin
          chk({tag, ":be"}, dmem_be, ref_be(f3, int'(addr % 4)));
          chk({tag, ":wdata"}, dmem_wdata, ref_wdata(f3, sdata));
        end
      end
      if (i < done_at) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    chk({tag, ":wb_valid"}, wb_valid, 1);
    chk({tag, ":wb_reg_write"}, wb_reg_write, (kind != 2 && !e));
    chk({tag, ":wb_mem_err"}, wb_mem_err, e);
    chk({tag, ":wb_rd"}, wb_rd, rd);
    if (!e) chk({tag, ":wb_data"}, wb_data, (kind == 1) ? ref_load(f3, int'(addr % 4), rdata) : addr);
  endtask

  initial begin
    int kind;
    int f3;
    logic [31:0] addr;
    int ld_codes[5] = '{0, 1, 2, 4, 5};

    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    run_instr("sw", 2, 2, 5'd0, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0);
    run_instr("sb", 2, 0, 5'd0, 32'h203, 32'h000000A5, 0, 0, 32'h0);
    run_instr("lb", 1, 0, 5'd7, 32'h101, 32'h0, 0, 1, 32'h000080FF);
    chk("lb_literal", wb_data, 32'hFFFFFF80);
    run_instr("lbu", 1, 4, 5'd7, 32'h101, 32'h0, 0, 1, 32'h000080FF);
    chk("lbu_literal", wb_data, 32'h00000080);
    run_instr("lh", 1, 1, 5'd9, 32'h102, 32'h0, 3, 2, 32'h80011234);
    chk("lh_literal", wb_data, 32'hFFFF8001);
    run_instr("lw_mis", 1, 2, 5'd3, 32'h102, 32'h0, 0, 1, 32'h0);
    run_instr("sh_bad_f3", 2, 3, 5'd0, 32'h100, 32'h1234, 0, 0, 32'h0);
    run_instr("add", 0, 0, 5'd5, 32'd42, 32'h0, 0, 0, 32'h0);
    chk("add_literal", wb_data, 32'd42);

    // Reset while a load is parked in WAIT, then a late response must be ignored.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_alu_result = 32'h200; ex_funct3 = 3'b010;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1; ex_rd = 5'd4;
    @(posedge clk); #1;
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    #3 chk("rst_wait:req", dmem_req, 1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #3 chk("rst_wait:stall", mem_stall, 1);
    chk("rst_wait:req_off", dmem_req, 0);
    rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    #3 chk("late_rvalid:stall", mem_stall, 0);
    chk("late_rvalid:req", dmem_req, 0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("late_rvalid:wb_valid", wb_valid, 0);
    chk("late_rvalid:wb_data", wb_data, 0);

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(2));
      if (kind == 1) f3 = ld_codes[$urandom_range(4)];
      else           f3 = int'($urandom_range(2));
      if ($urandom_range(4) == 0) f3 = int'($urandom_range(7));
      if (kind == 0) f3 = 0;
      addr = $urandom;
      if ($urandom_range(1) == 1) addr[1:0] = 2'b00;
      run_instr($sformatf("rnd%0d", n), kind, f3, 5'($urandom), addr, $urandom,
                int'($urandom_range(3)), int'($urandom_range(3, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and drives a req/gnt/rvalid data-memory port with wait-state handling.
- Performs byte/half/word store lane steering and load alignment/extension.
- Produces the MEM/WB register, the MEM-stage forwarding value, and a stall to the hazard unit.

Parameters:
- WIDTH, 32 (from all_pkgs), datapath and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_alu_result  in  WIDTH  ALU result / effective address
- ex_store_data  in  WIDTH  forwarded rs2 value
- ex_rd  in  5  destination register
- ex_funct3  in  3  access size/sign
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_reg_write  in  1  writes rd
- dmem_req  out  1  request valid
- dmem_we  out  1  write request
- dmem_addr  out  WIDTH  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  WIDTH  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  WIDTH  read data
- mem_stall  out  1  freeze IF/ID/EX; hold EX/MEM
- fwd_from_mem  out  WIDTH  EX/MEM ALU result for forwarding
- wb_valid  out  1  MEM/WB valid
- wb_rd  out  5  MEM/WB rd
- wb_reg_write  out  1  MEM/WB write enable
- wb_data  out  WIDTH  load data or ALU result
- wb_mem_err  out  1  misaligned/illegal access retired (one-cycle pulse)

Behaviour:
- Reset state:
  - The asynchronous reset clears every register: FSM to IDLE, M valid 0, and all wb_* outputs, fwd_from_mem and all dmem_* outputs to 0.
  - An rvalid arriving after reset while the FSM is in IDLE is ignored.
- EX/MEM register:
  - When mem_stall=0, capture all ex_* fields on the clock edge; m_valid <= ex_valid.
  - When mem_stall=1, hold all fields.
  - fwd_from_mem = captured alu_result.
- Access present = m_valid & (mem_read | mem_write).
- Error detection:
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Illegal: load funct3 in {011,110,111}; store funct3 > 010.
  - Either condition: no dmem_req. The instruction completes immediately with wb_reg_write=0 and wb_mem_err=1.
- FSM (mem_state_t):
  - IDLE: for a good access, dmem_req=1 combinationally.
    - gnt=1 and store: complete this cycle; stay in IDLE.
    - gnt=1 and load: go to WAIT.
    - gnt=0: go to REQ.
  - REQ: hold req, addr, be, wdata and we stable until gnt; then store→IDLE (complete), load→WAIT.
  - WAIT: dmem_req=0. On rvalid, capture aligned and extended data, complete, go to IDLE.
- mem_stall = access present & not completing this cycle. Non-access instructions never stall.
- Latency:
  - Store with immediate gnt: 0 stall cycles.
  - Load: minimum 1 stall cycle, since rvalid arrives at least one cycle after gnt.
- MEM/WB register, on each edge:
  - wb_valid <= m_valid & complete; when stalled, insert a bubble (wb_valid=0, wb_reg_write=0, wb_mem_err=0).
  - wb_data <= load ? extended rdata : alu_result.
- Store steering:
  - SB: be = 0001<<addr[1:0], byte replicated ×4.
  - SH: be = 0011<<(2·addr[1]), half replicated ×2.
  - SW: be = 1111.
  - dmem_addr = {addr[WIDTH-1:2],2'b00}.
- Load extension:
  - Select lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Simultaneous gnt and rvalid in REQ: rvalid is ignored; a response is only legal in WAIT.
- Reset asserted mid-access: request is abandoned, no writeback occurs.

Decomposition:
- all_pkgs additions:
  - funct3 constants LD_B/LD_H/LD_W/LD_BU/LD_HU and ST_B/ST_H/ST_W.
  - mem_state_t enum {IDLE, REQ, WAIT}.
  - ex_mem_t packed struct for the EX/MEM fields.
- Sub-module mem_align, purely combinational: funct3, addr[1:0], store data, rdata → be, wdata, extended load data, misaligned/illegal flag.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, gnt same cycle → dmem_be=1111, dmem_addr=0x104, mem_stall=0, next cycle wb_valid=1, wb_reg_write=0.
- SB addr 0x203, data 0x000000A5 → be=1000, wdata=0xA5A5A5A5.
- LB addr 0x101, gnt immediate, rvalid next cycle with rdata 0x0000_80FF → exactly one stall cycle, wb_data=0xFFFFFF80 (byte lane 1 = 0x80, sign-extended); LBU same → 0x00000080.
- LH addr 0x102, gnt delayed 3 cycles, rvalid 2 cycles later with rdata 0x8001_1234 → req stable 4 cycles, mem_stall high 5 cycles, wb_data=0xFFFF8001.
- LW addr 0x102 → no dmem_req, no stall, wb_mem_err=1 for one cycle, wb_reg_write=0.
- ADD (non-memory) result 42, rd=5, then rst pulsed during a WAIT → ADD gives wb_data=42 next cycle with no stall; after reset all outputs are 0 and a late rvalid is ignored.
